mem_wb_elastic_reg: RTL and testbench

Parametrised MEM→WB pipeline boundary with valid/ready flow control, an optional 2-entry skid buffer, synchronous flush and in-stage result selection. Sits between the data-cache/memory stage and register-file writeback. Generalises the plain enable-stalled MEM/WB register: backpressure propagates without a combinational ready path, and a selected writeback result plus forwarding qualifiers are produced directly.

---
 rtl/mem_wb_pkg.sv | 20 ++
 rtl/mem_wb_elastic_reg_skid_buffer.sv | 97 +++++++++
 rtl/mem_wb_elastic_reg.sv | 70 +++++++
 tb/tb_mem_wb_elastic_reg.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_pkg.sv
// Shared encodings for the MEM->WB elastic boundary.
package mem_wb_pkg;

  // Writeback result source select; 2'b11 is reserved and falls back to ALU.
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'b00,
    SKID_ONE   = 2'b01,
    SKID_FULL  = 2'b10
  } skid_state_e;

  // PCPlus4 + ALUResult + ReadData + RegWrite + ResultSrc + Rd
  function automatic int payload_width(input int data_width, input int reg_addr_width);
    return 3 * data_width + 1 + 2 + reg_addr_width;
  endfunction

endpackage

// File: rtl/mem_wb_elastic_reg_skid_buffer.sv
// Generic valid/ready stage: single register, or main + skid pair with a
// ready that depends only on local state.
//
// state      | meaning
// SKID_EMPTY | nothing held, downstream valid low
// SKID_ONE   | main register holds the oldest entry
// SKID_FULL  | main and skid both hold entries, upstream stalled
module mem_wb_elastic_reg_skid_buffer
  import mem_wb_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SKID_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] up_data,
  output logic             dn_valid,
  input  logic             dn_ready,
  output logic [WIDTH-1:0] dn_data
);

  skid_state_e      state_q, state_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             push, pop;
  logic             load_main_up, load_main_skid;

  assign dn_valid = (state_q != SKID_EMPTY);
  assign dn_data  = main_q;
  // Without the skid slot the only way to take a new entry while full is to
  // hand the current one off in the same cycle.
  assign up_ready = (SKID_EN != 0) ? (state_q != SKID_FULL) : (!dn_valid || dn_ready);
  assign push     = up_valid && up_ready;
  assign pop      = dn_valid && dn_ready;

  // Next-state and main-register load selection; flush overrides everything.
  always_comb begin
    state_d        = state_q;
    load_main_up   = 1'b0;
    load_main_skid = 1'b0;
    if (flush) begin
      state_d = SKID_EMPTY;
    end else begin
      case (state_q)
        SKID_EMPTY: begin
          if (push) begin
            state_d      = SKID_ONE;
            load_main_up = 1'b1;
          end
        end
        SKID_ONE: begin
          if (push && pop) begin
            load_main_up = 1'b1;
          end else if (push) begin
            state_d = SKID_FULL;
          end else if (pop) begin
            state_d = SKID_EMPTY;
          end
        end
        SKID_FULL: begin
          if (pop) begin
            state_d        = SKID_ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_d = SKID_EMPTY;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= SKID_EMPTY;
    else        state_q <= state_d;
  end

  // Main register loads only on accept or skid promotion; otherwise it holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              main_q <= '0;
    else if (load_main_up)   main_q <= up_data;
    else if (load_main_skid) main_q <= skid_q;
  end

  if (SKID_EN != 0) begin : g_skid
    // Skid captures the entry that arrives while main is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) skid_q <= '0;
      else if (!flush && state_q == SKID_ONE && push && !pop) skid_q <= up_data;
    end
  end else begin : g_no_skid
    assign skid_q = '0;
  end

endmodule

// File: rtl/mem_wb_elastic_reg.sv
// MEM->WB pipeline boundary: elastic register plus writeback result select
// and the register-file write qualifier.
module mem_wb_elastic_reg
  import mem_wb_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int SKID_EN        = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      valid_m,
  output logic                      ready_m,
  input  logic [DATA_WIDTH-1:0]     PCPlus4_m,
  input  logic [DATA_WIDTH-1:0]     ALUResult_m,
  input  logic [DATA_WIDTH-1:0]     ReadData_m,
  input  logic                      RegWrite_m,
  input  logic [1:0]                ResultSrc_m,
  input  logic [REG_ADDR_WIDTH-1:0] Rd_m,
  output logic                      valid_w,
  input  logic                      ready_w,
  output logic [DATA_WIDTH-1:0]     PCPlus4_w,
  output logic [DATA_WIDTH-1:0]     ALUResult_w,
  output logic [DATA_WIDTH-1:0]     ReadData_w,
  output logic                      RegWrite_w,
  output logic [1:0]                ResultSrc_w,
  output logic [REG_ADDR_WIDTH-1:0] Rd_w,
  output logic [DATA_WIDTH-1:0]     Result_w,
  output logic                      wb_en_w
);

  localparam int PAYLOAD_W = payload_width(DATA_WIDTH, REG_ADDR_WIDTH);

  logic [PAYLOAD_W-1:0] payload_m;
  logic [PAYLOAD_W-1:0] payload_w;

  assign payload_m = {PCPlus4_m, ALUResult_m, ReadData_m, RegWrite_m, ResultSrc_m, Rd_m};

  mem_wb_elastic_reg_skid_buffer #(
    .WIDTH   (PAYLOAD_W),
    .SKID_EN (SKID_EN)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .up_valid (valid_m),
    .up_ready (ready_m),
    .up_data  (payload_m),
    .dn_valid (valid_w),
    .dn_ready (ready_w),
    .dn_data  (payload_w)
  );

  assign {PCPlus4_w, ALUResult_w, ReadData_w, RegWrite_w, ResultSrc_w, Rd_w} = payload_w;

  // Result select works on registered fields only, so no input reaches Result_w.
  always_comb begin
    case (ResultSrc_w)
      RES_ALU: Result_w = ALUResult_w;
      RES_MEM: Result_w = ReadData_w;
      RES_PC4: Result_w = PCPlus4_w;
      default: Result_w = ALUResult_w;
    endcase
  end

  // x0 is hardwired, so a write to it is never a real writeback.
  assign wb_en_w = valid_w && RegWrite_w && (Rd_w != '0);

endmodule

// File: tb/tb_mem_wb_elastic_reg.sv
module tb_mem_wb_elastic_reg;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic        rw;
    logic [1:0]  src;
    logic [4:0]  rd;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic valid_m = 1'b0;
  logic ready_w = 1'b1;
  ent_t in_e = '0;

  logic [31:0] pc4_w [2];
  logic [31:0] alu_w [2];
  logic [31:0] rdata_w [2];
  logic [31:0] res_w [2];
  logic        rw_w [2];
  logic [1:0]  src_w [2];
  logic [4:0]  rd_w [2];
  logic        vw [2];
  logic        rm [2];
  logic        wb [2];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input int d, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s [dut%0d]: got %0h expected %0h at %0t", name, d, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] sel(input ent_t e);
    case (e.src)
      2'b01:   return e.rdata;
      2'b10:   return e.pc4;
      default: return e.alu;
    endcase
  endfunction

  // dut index 0: SKID_EN=0, dut index 1: SKID_EN=1; both see the same stimulus
  for (genvar g = 0; g < 2; g++) begin : d
    localparam bit SK = (g == 1);
    ent_t out_e;
    ent_t q[$];
    ent_t head = '0;

    mem_wb_elastic_reg #(
      .DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .SKID_EN(g)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .valid_m(valid_m), .ready_m(rm[g]),
      .PCPlus4_m(in_e.pc4), .ALUResult_m(in_e.alu), .ReadData_m(in_e.rdata),
      .RegWrite_m(in_e.rw), .ResultSrc_m(in_e.src), .Rd_m(in_e.rd),
      .valid_w(vw[g]), .ready_w(ready_w),
      .PCPlus4_w(pc4_w[g]), .ALUResult_w(alu_w[g]), .ReadData_w(rdata_w[g]),
      .RegWrite_w(rw_w[g]), .ResultSrc_w(src_w[g]), .Rd_w(rd_w[g]),
      .Result_w(res_w[g]), .wb_en_w(wb[g])
    );

    assign out_e = {pc4_w[g], alu_w[g], rdata_w[g], rw_w[g], src_w[g], rd_w[g]};

    // reference: FIFO of capacity 1 or 2; outputs show the head, or the last head when empty
    always @(posedge clk or negedge rst_n) begin
      bit rdy, pop, push;
      if (!rst_n) begin
        q.delete();
        head = '0;
      end else if (flush) begin
        q.delete();
      end else begin
        rdy  = SK ? (q.size() < 2) : (q.size() == 0 || ready_w);
        pop  = (q.size() > 0) && ready_w;
        push = valid_m && rdy;
        if (pop) void'(q.pop_front());
        if (push) q.push_back(in_e);
        if (q.size() > 0) head = q[0];
      end
    end

    always @(negedge clk) begin
      ent_t e;
      bit rdy, v;
      if (rst_n) begin
        v   = (q.size() > 0);
        e   = v ? q[0] : head;
        rdy = SK ? (q.size() < 2) : (!v || ready_w);
        chk("model_valid_w", g, 128'(vw[g]), 128'(v));
        chk("model_ready_m", g, 128'(rm[g]), 128'(rdy));
        chk("model_payload", g, 128'(out_e), 128'(e));
        chk("model_result",  g, 128'(res_w[g]), 128'(sel(e)));
        chk("model_wb_en",   g, 128'(wb[g]), 128'(v && e.rw && e.rd != 5'd0));
      end
    end
  end

  task automatic put(input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] rdata,
                     input logic [31:0] pc4, input logic [1:0] src, input logic rw);
    valid_m    = 1'b1;
    in_e.rd    = rd;
    in_e.alu   = alu;
    in_e.rdata = rdata;
    in_e.pc4   = pc4;
    in_e.src   = src;
    in_e.rw    = rw;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // single entry into an empty stage, then check both DUTs the cycle after
  task automatic one(input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] rdata,
                     input logic [31:0] pc4, input logic [1:0] src, input logic rw,
                     input logic [31:0] exp_res, input logic exp_wb);
    cyc();
    ready_w = 1'b1;
    put(rd, alu, rdata, pc4, src, rw);
    cyc();
    valid_m = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("sel_valid", k, 128'(vw[k]), 128'(1));
      chk("sel_result", k, 128'(res_w[k]), 128'(exp_res));
      chk("sel_wb_en", k, 128'(wb[k]), 128'(exp_wb));
    end
  endtask

  initial begin
    // reset held from time 0
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_valid", k, 128'(vw[k]), 128'(0));
      chk("rst_ready", k, 128'(rm[k]), 128'(1));
      chk("rst_result", k, 128'(res_w[k]), 128'(0));
    end
    rst_n = 1'b1;

    // stream of 4 with ready_w=1
    for (int i = 1; i <= 5; i++) begin
      cyc();
      ready_w = 1'b1;
      if (i <= 4) put(5'(i), 32'(16 * i), 32'h0, 32'h0, 2'b00, 1'b1);
      else valid_m = 1'b0;
      @(negedge clk);
      if (i >= 2) begin
        for (int k = 0; k < 2; k++) begin
          chk("stream_valid", k, 128'(vw[k]), 128'(1));
          chk("stream_rd", k, 128'(rd_w[k]), 128'(i - 1));
          chk("stream_result", k, 128'(res_w[k]), 128'(16 * (i - 1)));
          chk("stream_wb_en", k, 128'(wb[k]), 128'(1));
        end
      end
    end

    // backpressure: ready_w low for three cycles
    cyc(); ready_w = 1'b1; put(5'd1, 32'h100, 32'h0, 32'h0, 2'b00, 1'b1);
    @(negedge clk);
    chk("bp_empty_valid", 1, 128'(vw[1]), 128'(0));
    cyc(); ready_w = 1'b0; put(5'd2, 32'h200, 32'h0, 32'h0, 2'b00, 1'b1);
    @(negedge clk);
    chk("bp_c2_rd", 1, 128'(rd_w[1]), 128'(1));
    chk("bp_c2_ready", 1, 128'(rm[1]), 128'(1));
    chk("bp_c2_ready_noskid", 0, 128'(rm[0]), 128'(0));
    cyc(); ready_w = 1'b0; put(5'd3, 32'h300, 32'h0, 32'h0, 2'b00, 1'b1);
    @(negedge clk);
    chk("bp_full_ready", 1, 128'(rm[1]), 128'(0));
    chk("bp_c3_rd", 1, 128'(rd_w[1]), 128'(1));
    chk("bp_c3_ready_noskid", 0, 128'(rm[0]), 128'(0));
    cyc();
    @(negedge clk);
    chk("bp_c4_ready", 1, 128'(rm[1]), 128'(0));
    chk("bp_c4_rd", 1, 128'(rd_w[1]), 128'(1));
    cyc(); ready_w = 1'b1;
    @(negedge clk);
    chk("bp_c5_rd", 1, 128'(rd_w[1]), 128'(1));
    chk("bp_c5_ready", 1, 128'(rm[1]), 128'(0));
    chk("bp_c5_ready_noskid", 0, 128'(rm[0]), 128'(1));
    cyc();
    @(negedge clk);
    chk("bp_c6_rd", 1, 128'(rd_w[1]), 128'(2));
    chk("bp_c6_ready", 1, 128'(rm[1]), 128'(1));
    cyc(); valid_m = 1'b0;
    @(negedge clk);
    chk("bp_c7_rd", 1, 128'(rd_w[1]), 128'(3));
    chk("bp_c7_valid", 1, 128'(vw[1]), 128'(1));
    cyc();
    @(negedge clk);
    chk("bp_drained", 1, 128'(vw[1]), 128'(0));

    // result select and x0 write
    one(5'd5, 32'h11, 32'hDEADBEEF, 32'h200, 2'b01, 1'b1, 32'hDEADBEEF, 1'b1);
    one(5'd6, 32'h22, 32'h33, 32'h104, 2'b10, 1'b1, 32'h104, 1'b1);
    one(5'd7, 32'h55, 32'h66, 32'h77, 2'b11, 1'b1, 32'h55, 1'b1);
    one(5'd0, 32'h99, 32'h0, 32'h0, 2'b00, 1'b1, 32'h99, 1'b0);
    one(5'd9, 32'hAB, 32'h0, 32'h0, 2'b00, 1'b0, 32'hAB, 1'b0);

    // flush while FULL with an entry offered
    cyc(); ready_w = 1'b1; valid_m = 1'b0;
    cyc(); put(5'd7, 32'h700, 32'h0, 32'h0, 2'b00, 1'b1);
    cyc(); ready_w = 1'b0; put(5'd8, 32'h800, 32'h0, 32'h0, 2'b00, 1'b1);
    cyc(); put(5'd9, 32'h900, 32'h0, 32'h0, 2'b00, 1'b1); flush = 1'b1;
    @(negedge clk);
    chk("fl_full_ready", 1, 128'(rm[1]), 128'(0));
    cyc(); flush = 1'b0; valid_m = 1'b0; ready_w = 1'b1;
    @(negedge clk);
    chk("fl_valid", 1, 128'(vw[1]), 128'(0));
    chk("fl_ready", 1, 128'(rm[1]), 128'(1));
    chk("fl_hold_rd", 1, 128'(rd_w[1]), 128'(7));
    chk("fl_valid_noskid", 0, 128'(vw[0]), 128'(0));
    for (int i = 0; i < 3; i++) begin
      cyc();
      @(negedge clk);
      chk("fl_no_ghost", 1, 128'(vw[1]), 128'(0));
    end

    // asynchronous reset while FULL, no clock edge in between
    cyc(); ready_w = 1'b1; put(5'd11, 32'hB00, 32'h0, 32'h0, 2'b00, 1'b1);
    cyc(); ready_w = 1'b0; put(5'd12, 32'hC00, 32'h0, 32'h0, 2'b00, 1'b1);
    cyc(); put(5'd13, 32'hD00, 32'h0, 32'h0, 2'b00, 1'b1);
    @(negedge clk);
    chk("ar_pre_ready", 1, 128'(rm[1]), 128'(0));
    chk("ar_pre_rd", 1, 128'(rd_w[1]), 128'(11));
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", 1, 128'(vw[1]), 128'(0));
    chk("ar_ready", 1, 128'(rm[1]), 128'(1));
    chk("ar_rd", 1, 128'(rd_w[1]), 128'(0));
    chk("ar_result", 1, 128'(res_w[1]), 128'(0));
    chk("ar_wb_en", 1, 128'(wb[1]), 128'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    valid_m = 1'b0;
    ready_w = 1'b1;

    // randomized traffic with varying backpressure and occasional flush
    for (int c = 0; c < 3000; c++) begin
      cyc();
      valid_m = ($urandom_range(0, 3) != 0);
      case (c / 1000)
        0:       ready_w = ($urandom_range(0, 3) != 0);
        1:       ready_w = ($urandom_range(0, 3) == 0);
        default: ready_w = $urandom_range(0, 1) == 1;
      endcase
      flush = ($urandom_range(0, 31) == 0);
      in_e  = {$urandom, $urandom, $urandom, 1'($urandom), 2'($urandom), 5'($urandom)};
    end
    cyc();
    flush = 1'b0;
    valid_m = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
